// File: rtl/spi_slave_mode_sync.sv
// SPI register-access slave, fully in the clk domain. SCK/SS_N/MOSI are
// oversampled and SCK edges are found in logic; frame = RW, address, data.
//
// state | meaning
// IDLE  | waiting for a synchronised ss_n falling edge
// CMD   | shifting in RW and address bits
// DATA  | shifting data in on sample edges, read data out on shift edges
// DONE  | frame complete, SCK ignored until ss_n rises
module spi_slave_mode_sync #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CPOL   = 0,
    parameter int CPHA   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int FRAME = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FRAME + 1);
    // Shift register only needs to hold the larger of {RW,addr} and data.
    localparam int SH_W  = (DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME);
    localparam logic SCK_IDLE    = (CPOL != 0);
    localparam logic SAMPLE_RISE = (CPOL == CPHA);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        sck_s_q, ss_s_q;
    logic [1:0]        mosi_s_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SH_W-2:0]   shift_q, shift_d;
    logic [SH_W-1:0]   shift_w;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              ld_q, ld_d;
    logic              frame_err_q, frame_err_d;

    logic sck_rise, sck_fall, sample_edge, shift_edge, ss_fall, ss_rise;

    // Synchronisers plus edge-detect stage. ss_n resets to "low" so that a
    // select already held low across reset never looks like a fresh fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s_q  <= {3{SCK_IDLE}};
            ss_s_q   <= 3'b000;
            mosi_s_q <= 2'b00;
        end else begin
            sck_s_q  <= {sck_s_q[1:0], sck};
            ss_s_q   <= {ss_s_q[1:0], ss_n};
            mosi_s_q <= {mosi_s_q[0], mosi};
        end
    end

    assign sck_rise    = sck_s_q[1] & ~sck_s_q[2];
    assign sck_fall    = ~sck_s_q[1] & sck_s_q[2];
    assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
    assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;
    assign ss_fall     = ~ss_s_q[1] & ss_s_q[2];
    assign ss_rise     = ss_s_q[1] & ~ss_s_q[2];
    assign shift_w     = {shift_q, mosi_s_q[1]};

    // Frame state register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            ld_q        <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            ld_q        <= ld_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state, strobe and shift logic; an ss_n rise beats any SCK edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        tx_d        = tx_q;
        miso_d      = 1'b0;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        ld_d        = rd_en_q;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    shift_d = '0;
                    tx_d    = '0;
                end
            end
            CMD: begin
                if (ss_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (sample_edge) begin
                    shift_d = shift_w[SH_W-2:0];
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_d == CNT_ADDR) begin
                        rw_d    = shift_w[ADDR_W];
                        addr_d  = shift_w[ADDR_W-1:0];
                        rd_en_d = ~shift_w[ADDR_W];
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                miso_d = miso_q;
                if (ss_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                end else begin
                    // Load cannot collide with a shift edge given the
                    // minimum SCK phase length.
                    if (ld_q) begin
                        tx_d = rd_data;
                    end else if (shift_edge) begin
                        miso_d = tx_q[DATA_W-1];
                        tx_d   = tx_q << 1;
                    end
                    if (sample_edge) begin
                        shift_d = shift_w[SH_W-2:0];
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_d == CNT_LAST) begin
                            wr_en_d = rw_q;
                            if (rw_q) begin
                                wr_data_d = shift_w[DATA_W-1:0];
                            end
                            state_d = DONE;
                            miso_d  = 1'b0;
                        end
                    end
                end
            end
            DONE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign miso      = miso_q;
    assign busy      = (state_q != IDLE);
    assign miso_oe   = busy;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_mode_sync.sv
// Bench for spi_slave_mode_sync: a mode-0 and a mode-3 instance driven by a
// bit-level SPI master, checked against table expectations and a frame-level
// reference model for random frames.
module tb_spi_slave_mode_sync;

    localparam int H = 6;   // SCK half period in clk cycles

    typedef struct {
        int         m;
        logic       rw;
        logic [3:0] a;
        logic [7:0] d;
        int         nbits;
        int         extra;
        logic       exp_wr;
        logic       exp_rd;
        logic       exp_err;
        logic [7:0] exp_miso;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic sck_r [2];
    logic ss_r  [2];
    logic mosi_r;
    logic miso_w [2], oe_w [2], wr_w [2], rd_w [2], err_w [2], busy_w [2];
    logic [3:0] addr_w [2];
    logic [7:0] wrd_w [2];
    logic [7:0] rdd_w [2];
    logic [7:0] rmem [16];

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr [2], n_rd [2], n_err [2], n_both [2], n_mhi [2], n_busy [2];
    logic [3:0] wr_a [2], rd_a [2];
    logic [7:0] wr_d [2];

    always #5 clk = ~clk;

    assign rdd_w[0] = rmem[addr_w[0]];
    assign rdd_w[1] = rmem[addr_w[1]];

    spi_slave_mode_sync #(.ADDR_W(4), .DATA_W(8), .CPOL(0), .CPHA(0)) u_m0 (
        .clk(clk), .rst(rst), .sck(sck_r[0]), .ss_n(ss_r[0]), .mosi(mosi_r),
        .miso(miso_w[0]), .miso_oe(oe_w[0]), .wr_en(wr_w[0]), .rd_en(rd_w[0]),
        .addr(addr_w[0]), .wr_data(wrd_w[0]), .rd_data(rdd_w[0]),
        .frame_err(err_w[0]), .busy(busy_w[0]));

    spi_slave_mode_sync #(.ADDR_W(4), .DATA_W(8), .CPOL(1), .CPHA(1)) u_m3 (
        .clk(clk), .rst(rst), .sck(sck_r[1]), .ss_n(ss_r[1]), .mosi(mosi_r),
        .miso(miso_w[1]), .miso_oe(oe_w[1]), .wr_en(wr_w[1]), .rd_en(rd_w[1]),
        .addr(addr_w[1]), .wr_data(wrd_w[1]), .rd_data(rdd_w[1]),
        .frame_err(err_w[1]), .busy(busy_w[1]));

    // Output monitor: counts strobe cycles and captures strobe-time values.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wr_w[k]) begin
                n_wr[k]++;
                wr_a[k] = addr_w[k];
                wr_d[k] = wrd_w[k];
            end
            if (rd_w[k]) begin
                n_rd[k]++;
                rd_a[k] = addr_w[k];
            end
            if (err_w[k]) n_err[k]++;
            if (wr_w[k] && rd_w[k]) n_both[k]++;
            if (miso_w[k]) n_mhi[k]++;
            if (busy_w[k]) n_busy[k]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr(input int m);
        n_wr[m] = 0; n_rd[m] = 0; n_err[m] = 0; n_both[m] = 0;
        n_mhi[m] = 0; n_busy[m] = 0;
        wr_a[m] = '0; rd_a[m] = '0; wr_d[m] = '0;
    endtask

    // One SPI bit period; instance 1 is CPHA=1 so its shift edge leads.
    task automatic do_bit(input int m, input logic b, output logic s);
        if (m == 1) sck_r[m] = ~sck_r[m];
        mosi_r = b;
        wclk(H);
        s = miso_w[m];
        sck_r[m] = ~sck_r[m];
        wclk(H);
        if (m == 0) sck_r[m] = ~sck_r[m];
    endtask

    // Frame-level reference model: what a frame must produce.
    function automatic vec_t model(input int m, input logic rw, input logic [3:0] a,
                                   input logic [7:0] d, input int nbits, input int extra);
        vec_t v;
        logic complete;
        complete   = (nbits >= 13);
        v.m        = m; v.rw = rw; v.a = a; v.d = d;
        v.nbits    = nbits; v.extra = extra;
        v.exp_wr   = complete && rw;
        v.exp_rd   = !rw && (nbits >= 5);
        v.exp_err  = !complete;
        v.exp_miso = (complete && !rw) ? rmem[a] : 8'h00;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        logic [12:0] bits;
        logic [7:0]  mb;
        logic        s;
        bits = {v.rw, v.a, v.d};
        mb   = '0;
        clr(v.m);
        ss_r[v.m] = 1'b0;
        wclk(4);
        chk({tag, " busy_in_frame"}, 32'(busy_w[v.m]), 32'd1);
        chk({tag, " oe_in_frame"}, 32'(oe_w[v.m]), 32'd1);
        for (int i = 0; i < v.nbits; i++) begin
            do_bit(v.m, bits[12-i], s);
            if (i >= 5) mb[12-i] = s;
        end
        for (int i = 0; i < v.extra; i++) begin
            do_bit(v.m, 1'($urandom_range(0, 1)), s);
        end
        wclk(4);
        ss_r[v.m] = 1'b1;
        wclk(8);
        chk({tag, " busy_after"}, 32'(busy_w[v.m]), 32'd0);
        chk({tag, " oe_after"}, 32'(oe_w[v.m]), 32'd0);
        chk({tag, " wr_count"}, 32'(n_wr[v.m]), 32'(v.exp_wr));
        chk({tag, " rd_count"}, 32'(n_rd[v.m]), 32'(v.exp_rd));
        chk({tag, " err_count"}, 32'(n_err[v.m]), 32'(v.exp_err));
        chk({tag, " wr_rd_overlap"}, 32'(n_both[v.m]), 32'd0);
        if (v.exp_wr) begin
            chk({tag, " wr_addr"}, 32'(wr_a[v.m]), 32'(v.a));
            chk({tag, " wr_data"}, 32'(wr_d[v.m]), 32'(v.d));
        end
        if (v.exp_rd) chk({tag, " rd_addr"}, 32'(rd_a[v.m]), 32'(v.a));
        if (v.nbits >= 13 && !v.rw) chk({tag, " miso_bits"}, 32'(mb), 32'(v.exp_miso));
        if (v.rw) chk({tag, " miso_quiet"}, 32'(n_mhi[v.m]), 32'd0);
    endtask

    initial begin
        vec_t tbl [8];
        vec_t v;
        logic [12:0] bits;
        logic s;

        for (int i = 0; i < 16; i++) rmem[i] = 8'($urandom_range(0, 255));
        rmem[3] = 8'hA5;
        rst = 1'b1;
        sck_r[0] = 1'b0; sck_r[1] = 1'b1;
        ss_r[0] = 1'b1;  ss_r[1] = 1'b1;
        mosi_r = 1'b0;
        clr(0); clr(1);

        //          m  rw    a      d      nb ex wr    rd    err   miso
        tbl[0] = '{0, 1'b1, 4'hA, 8'h5C, 13, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{0, 1'b0, 4'h3, 8'h00, 13, 0, 1'b0, 1'b1, 1'b0, 8'hA5};
        tbl[2] = '{1, 1'b1, 4'hA, 8'h5C, 13, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{1, 1'b0, 4'h3, 8'h00, 13, 0, 1'b0, 1'b1, 1'b0, 8'hA5};
        tbl[4] = '{0, 1'b1, 4'h5, 8'hFF,  7, 0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[5] = '{0, 1'b1, 4'h3, 8'h11, 13, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[6] = '{0, 1'b1, 4'h7, 8'hC3, 13, 8, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[7] = '{1, 1'b0, 4'h3, 8'h00,  9, 0, 1'b0, 1'b1, 1'b1, 8'h00};

        wclk(3);
        for (int k = 0; k < 2; k++) begin
            chk("reset outputs", {miso_w[k], oe_w[k], wr_w[k], rd_w[k], err_w[k],
                busy_w[k], addr_w[k], wrd_w[k]}, 32'd0);
        end
        rst = 1'b0;
        wclk(4);

        for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Reset mid data phase with ss_n held low across it.
        clr(0);
        bits = {1'b1, 4'h6, 8'h9E};
        ss_r[0] = 1'b0;
        wclk(4);
        for (int i = 0; i < 8; i++) do_bit(0, bits[12-i], s);
        rst = 1'b1;
        wclk(1);
        chk("rst miso", 32'(miso_w[0]), 32'd0);
        chk("rst miso_oe", 32'(oe_w[0]), 32'd0);
        chk("rst busy", 32'(busy_w[0]), 32'd0);
        chk("rst strobes", {wr_w[0], rd_w[0], err_w[0]}, 32'd0);
        chk("rst addr", 32'(addr_w[0]), 32'd0);
        chk("rst wr_data", 32'(wrd_w[0]), 32'd0);
        rst = 1'b0;
        clr(0);
        for (int i = 8; i < 13; i++) do_bit(0, bits[12-i], s);
        wclk(4);
        ss_r[0] = 1'b1;
        wclk(8);
        chk("post-rst wr_count", 32'(n_wr[0]), 32'd0);
        chk("post-rst err_count", 32'(n_err[0]), 32'd0);
        chk("post-rst busy_cycles", 32'(n_busy[0]), 32'd0);
        apply(model(0, 1'b1, 4'h6, 8'h9E, 13, 0), "after_rst");

        for (int i = 0; i < 20; i++) begin
            int nb;
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : 13;
            v = model($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                      nb, (nb == 13) ? $urandom_range(0, 2) : 0);
            apply(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
